ring_stimulus_sequencer: RTL and testbench
==========================================

# ring_stimulus_sequencer

Upstream driver for the three-stage instance ring: it accepts queued commands, each a 4-bit select plus a control bit, and applies them to the ring's `s` and `c` inputs for a programmed number of cycles. After applying a command it watches the ring's `o` output for an acknowledge, bounded by a timeout. It then reports completion or timeout and moves on to the next queued command.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `HOLD_W`, 8: width of the per-command hold count.
- `TIMEOUT`, 16: maximum number of cycles spent waiting for `o`; at least 1.

Ports:
- `clk`  in  1  single clock; all logic rises on its posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_s`  in  4  select value to drive.
- `cmd_c`  in  1  control value to drive.
- `cmd_hold`  in  HOLD_W  apply duration in cycles; 0 is treated as 1.
- `s`  out  4  to ring select input.
- `c`  out  1  to ring control input.
- `o`  in  1  acknowledge from ring output.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_timeout`  out  1  qualifies `done_valid`: 1 = timeout, 0 = acknowledged.
- `busy`  out  1  1 whenever the state is not IDLE.
- `fifo_level`  out  $clog2(DEPTH)+1  number of queued entries.

## Operation
- Command push happens when `cmd_valid && cmd_ready`. `cmd_ready = (fifo_level != DEPTH)`, a combinational function of the registered level.
- State machine states: IDLE, APPLY, WAIT_O, REPORT.
- IDLE:
  - `s=0`, `c=0`.
  - If the FIFO is non-empty: pop the head, register `s`, `c` and the hold count from it, and go to APPLY.
- APPLY:
  - `s` and `c` are held.
  - The counter counts max(`cmd_hold`,1) cycles, then the state goes to WAIT_O with the wait counter cleared.
  - `o` is ignored in this state.
- WAIT_O:
  - `s` and `c` are still held. `o` is sampled each cycle.
  - If `o==1`: go to REPORT with timeout=0.
  - Otherwise, once TIMEOUT cycles have elapsed: go to REPORT with timeout=1.
  - If `o` rises on the final cycle, the acknowledge wins.
- REPORT:
  - `done_valid=1` for exactly one cycle, with `done_timeout` valid.
  - `s=0`, `c=0`. Next state is IDLE unconditionally.
- Pushes are accepted in every state. A push and a pop in the same cycle leave `fifo_level` unchanged.
- The FIFO is full when `fifo_level==DEPTH`. `cmd_ready` deasserts then, and there is no overwrite.
- The FIFO is empty when `fifo_level==0`. IDLE stays in IDLE.
- Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `s=0`, `c=0`, `done_valid=0`, `done_timeout=0`, `busy=0`.
  - `fifo_level=0`, `cmd_ready=1`, state=IDLE.
- `rst_n` low clears all state immediately, mid-command included. Queued entries are discarded and no done pulse is issued.
- Push at edge N makes the entry visible at edge N+1. If the block is idle, APPLY starts at edge N+1 and `s`/`c` change then.
- APPLY occupies exactly max(hold,1) cycles.
- In WAIT_O:
  - Acknowledge path: `o` high in the k-th WAIT_O cycle gives REPORT k cycles after WAIT_O is entered (k ≤ TIMEOUT).
  - Timeout path: REPORT comes exactly TIMEOUT cycles after WAIT_O is entered.
- Minimum command period is 1 + hold + 1 + 1 cycles (IDLE, APPLY, WAIT_O, REPORT).
- `o` is not registered internally by default. It is sampled at the edge.

## Configuration
- `RING_SEQ_SYNC_O_EN` defined:
  - `o` passes through a two-flop synchronizer, reset to 0, before being used in WAIT_O.
  - Acknowledge latency grows by 2 cycles. The timeout count is unchanged.
- Undefined: `o` is used directly, as described above.

## Structure
- `ring_seq_pkg` holds:
  - the state enum `ring_seq_state_e`;
  - the typedef `ring_cmd_t` (`s[3:0]`, `c`, `hold[HOLD_W-1:0]`, with HOLD_W default as a package localparam);
  - the localparam `RING_SEL_W = 4`.
- One sub-module, `ring_seq_fifo`: a parameterized synchronous FIFO with push/pop, full, empty and level outputs.

## Test plan
- Reset check: with `rst_n` low, expect `s=0`, `c=0`, `cmd_ready=1`, `fifo_level=0`, `done_valid=0`.
- Acknowledge path: push {s=4'hA, c=1, hold=3}, with `o` rising on the 2nd WAIT_O cycle.
  - Expect `s=A`, `c=1` for 3+2 cycles.
  - Expect `done_valid=1`, `done_timeout=0`, then `s=0`.
- Timeout path: push {s=5, c=0, hold=0}, with `o` held at 0.
  - Expect APPLY to last 1 cycle.
  - Expect `done_timeout=1` exactly 16 WAIT_O cycles later.
- FIFO full and wrap: push 5 commands back-to-back with DEPTH=4 while the first is active.
  - Expect `cmd_ready=0` at level 4 and the 5th to stall.
  - Then expect all 5 to execute in order.
- Reset mid-command: assert `rst_n` low during APPLY with 2 entries queued.
  - Expect `s=0` immediately, `fifo_level=0`, and no `done_valid` after release.
- With `RING_SEQ_SYNC_O_EN`: repeat the acknowledge-path test. Expect `done_valid` 2 cycles later than without the macro.

Source files
------------

// File: rtl/ring_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_seq_pkg
// Brief    : Shared types and constants for the ring stimulus sequencer:
//            FSM state encoding, command layout and select width.
// Revision : 1.0 - initial release
// ============================================================================
package ring_seq_pkg;

    // Width of the ring select input.
    localparam int RING_SEL_W  = 4;

    // Default width of the per-command hold count.
    localparam int RING_HOLD_W = 8;

    // Sequencer states: fetch, drive, wait for acknowledge, report.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_WAIT_O = 2'd2,
        ST_REPORT = 2'd3
    } ring_seq_state_e;

    // One queued command at the default hold width.
    typedef struct packed {
        logic [RING_SEL_W-1:0]  s;
        logic                   c;
        logic [RING_HOLD_W-1:0] hold;
    } ring_cmd_t;

endpackage : ring_seq_pkg
`default_nettype wire

// File: rtl/ring_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ring_seq_fifo
// Brief    : Synchronous FIFO with combinational read of the head entry,
//            full/empty flags and an occupancy level. Pushes when full and
//            pops when empty are ignored. DEPTH must be a power of two >= 2
//            so the pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module ring_seq_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage write; contents need no reset because the level gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign full    = (r_level == c_FULL_LVL);
    assign empty   = (r_level == '0);
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule : ring_seq_fifo
`default_nettype wire

// File: rtl/ring_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ring_stimulus_sequencer
// Brief    : Queues select/control commands and drives them onto the ring's
//            s/c inputs for max(hold,1) cycles, then waits up to TIMEOUT
//            cycles for the ring's o acknowledge and emits a one-cycle
//            completion pulse flagged as acknowledged or timed out.
//            Build option RING_SEQ_SYNC_O_EN: route o through a two-flop
//            synchronizer before it is used (acknowledge latency +2).
// Revision : 1.0 - initial release
// ============================================================================
module ring_stimulus_sequencer
    import ring_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLD_W  = RING_HOLD_W,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [RING_SEL_W-1:0]   cmd_s,
    input  logic                    cmd_c,
    input  logic [HOLD_W-1:0]       cmd_hold,
    output logic [RING_SEL_W-1:0]   s,
    output logic                    c,
    input  logic                    o,
    output logic                    done_valid,
    output logic                    done_timeout,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int c_CMD_W  = RING_SEL_W + 1 + HOLD_W;
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]   c_HOLD_ONE  = HOLD_W'(1);

    ring_seq_state_e        r_state;
    ring_seq_state_e        w_state_nxt;
    logic [RING_SEL_W-1:0]  r_s;
    logic [RING_SEL_W-1:0]  w_s_nxt;
    logic                   r_c;
    logic                   w_c_nxt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [HOLD_W-1:0]      w_hold_cnt_nxt;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic [c_WAIT_W-1:0]    w_wait_cnt_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
    logic                   w_pop;
    logic                   w_o_use;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_CMD_W-1:0]     w_push_data;
    logic [c_CMD_W-1:0]     w_pop_data;

    assign w_push_data = {cmd_s, cmd_c, cmd_hold};
    assign cmd_ready   = !w_fifo_full;

    ring_seq_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (c_CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .wr_data (w_push_data),
        .pop     (w_pop),
        .rd_data (w_pop_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

`ifdef RING_SEQ_SYNC_O_EN
    logic r_o_meta;
    logic r_o_sync;

    // Two-flop synchronizer for the ring acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_meta <= 1'b0;
            r_o_sync <= 1'b0;
        end else begin
            r_o_meta <= o;
            r_o_sync <= r_o_meta;
        end
    end

    assign w_o_use = r_o_sync;
`else
    assign w_o_use = o;
`endif

    // State and per-command registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_c        <= 1'b0;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_c        <= w_c_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state, counters and ring/report outputs for the current state.
    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_c_nxt        = r_c;
        w_hold_cnt_nxt = r_hold_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        w_pop          = 1'b0;
        s              = '0;
        c              = 1'b0;
        done_valid     = 1'b0;
        done_timeout   = 1'b0;
        busy           = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_s_nxt        = w_pop_data[c_CMD_W-1 -: RING_SEL_W];
                    w_c_nxt        = w_pop_data[HOLD_W];
                    w_hold_cnt_nxt = w_pop_data[HOLD_W-1:0];
                    w_state_nxt    = ST_APPLY;
                end
            end

            ST_APPLY: begin
                s = r_s;
                c = r_c;
                // A hold of 0 or 1 both give a single APPLY cycle.
                if (r_hold_cnt <= c_HOLD_ONE) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_WAIT_O;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - c_HOLD_ONE;
                end
            end

            ST_WAIT_O: begin
                s = r_s;
                c = r_c;
                // Acknowledge is checked first so it wins on the last cycle.
                if (w_o_use) begin
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_REPORT;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_REPORT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end

            ST_REPORT: begin
                done_valid   = 1'b1;
                done_timeout = r_timeout;
                w_state_nxt  = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : ring_stimulus_sequencer
`default_nettype wire

// File: tb/tb_ring_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_stimulus_sequencer
// Brief    : Directed self-checking bench for ring_stimulus_sequencer:
//            reset, acknowledge path, acknowledge on the final wait cycle,
//            timeout path, FIFO full/stall/wrap ordering, reset mid-command.
//            Expected acknowledge timing accounts for RING_SEQ_SYNC_O_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_stimulus_sequencer;
    import ring_seq_pkg::*;

    localparam int c_DEPTH   = 4;
    localparam int c_HOLD_W  = 8;
    localparam int c_TIMEOUT = 16;
`ifdef RING_SEQ_SYNC_O_EN
    localparam int c_SYNC_LAT = 2;
`else
    localparam int c_SYNC_LAT = 0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [RING_SEL_W-1:0]  cmd_s;
    logic                   cmd_c;
    logic [c_HOLD_W-1:0]    cmd_hold;
    logic [RING_SEL_W-1:0]  s;
    logic                   c;
    logic                   o;
    logic                   done_valid;
    logic                   done_timeout;
    logic                   busy;
    logic [$clog2(c_DEPTH):0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    ring_stimulus_sequencer #(
        .DEPTH   (c_DEPTH),
        .HOLD_W  (c_HOLD_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_s        (cmd_s),
        .cmd_c        (cmd_c),
        .cmd_hold     (cmd_hold),
        .s            (s),
        .c            (c),
        .o            (o),
        .done_valid   (done_valid),
        .done_timeout (done_timeout),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input ring_cmd_t cmd);
        cmd_valid = 1'b1;
        cmd_s     = cmd.s;
        cmd_c     = cmd.c;
        cmd_hold  = cmd.hold;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int i = 0;
        while (done_valid !== 1'b1 && i < bound) begin
            tick();
            i++;
        end
        chk(tag, {31'd0, done_valid}, 32'd1);
    endtask

    task automatic wait_sel(input string tag, input int bound);
        int i = 0;
        while (s === '0 && i < bound) begin
            tick();
            i++;
        end
        chk(tag, {31'd0, (s !== '0)}, 32'd1);
    endtask

    initial begin
        int seen_done;
        int seen_busy;
        int i;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_s     = '0;
        cmd_c     = 1'b0;
        cmd_hold  = '0;
        o         = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_s",       {28'd0, s}, 32'd0);
        chk("rst_c",       {31'd0, c}, 32'd0);
        chk("rst_ready",   {31'd0, cmd_ready}, 32'd1);
        chk("rst_level",   {29'd0, fifo_level}, 32'd0);
        chk("rst_done",    {31'd0, done_valid}, 32'd0);
        chk("rst_dto",     {31'd0, done_timeout}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy",   {31'd0, busy}, 32'd0);

        // ---------------- acknowledge path: s=A c=1 hold=3, o in 2nd wait cycle
        push(ring_cmd_t'{s: 4'hA, c: 1'b1, hold: 8'd3});
        chk("ack_level_q", {29'd0, fifo_level}, 32'd1);
        chk("ack_s_pre",   {28'd0, s}, 32'd0);
        tick();
        chk("ack_level_p", {29'd0, fifo_level}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("ack_s_hold",  {28'd0, s}, 32'hA);
            chk("ack_c_hold",  {31'd0, c}, 32'd1);
            chk("ack_no_done", {31'd0, done_valid}, 32'd0);
            chk("ack_busy",    {31'd0, busy}, 32'd1);
            if (k == 0) o = 1'b1;  // pulse during APPLY must be ignored
            if (k == 1) o = 1'b0;
            if (k == 4) o = 1'b1;  // rises in the 2nd WAIT_O cycle
            tick();
        end
        for (int k = 0; k < c_SYNC_LAT; k++) begin
            chk("ack_sync_s",    {28'd0, s}, 32'hA);
            chk("ack_sync_done", {31'd0, done_valid}, 32'd0);
            tick();
        end
        chk("ack_done",    {31'd0, done_valid}, 32'd1);
        chk("ack_dto",     {31'd0, done_timeout}, 32'd0);
        chk("ack_s_rep",   {28'd0, s}, 32'd0);
        chk("ack_c_rep",   {31'd0, c}, 32'd0);
        o = 1'b0;
        tick();
        chk("ack_done_1cy", {31'd0, done_valid}, 32'd0);
        chk("ack_idle",     {31'd0, busy}, 32'd0);

        // ---------------- acknowledge on the final wait cycle wins
        push(ring_cmd_t'{s: 4'h3, c: 1'b1, hold: 8'd1});
        tick();  // APPLY
        tick();  // WAIT_O entered
        for (int k = 0; k < c_TIMEOUT; k++) begin
            chk("last_no_done", {31'd0, done_valid}, 32'd0);
            if (k == c_TIMEOUT - 1 - c_SYNC_LAT) o = 1'b1;
            tick();
        end
        chk("last_done", {31'd0, done_valid}, 32'd1);
        chk("last_dto",  {31'd0, done_timeout}, 32'd0);
        o = 1'b0;
        tick();
        tick();

        // ---------------- timeout path: s=5 c=0 hold=0, o low
        push(ring_cmd_t'{s: 4'h5, c: 1'b0, hold: 8'd0});
        tick();
        chk("to_s_apply", {28'd0, s}, 32'h5);
        chk("to_c_apply", {31'd0, c}, 32'd0);
        tick();  // single APPLY cycle, now in WAIT_O
        chk("to_s_wait",  {28'd0, s}, 32'h5);
        for (int k = 0; k < c_TIMEOUT; k++) begin
            chk("to_no_done", {31'd0, done_valid}, 32'd0);
            tick();
        end
        chk("to_done", {31'd0, done_valid}, 32'd1);
        chk("to_dto",  {31'd0, done_timeout}, 32'd1);
        chk("to_s_rep", {28'd0, s}, 32'd0);
        tick();
        chk("to_done_1cy", {31'd0, done_valid}, 32'd0);
        chk("to_dto_clr",  {31'd0, done_timeout}, 32'd0);

        // ---------------- FIFO full, stall and wrap ordering
        o = 1'b1;
        push(ring_cmd_t'{s: 4'hF, c: 1'b1, hold: 8'd20});
        tick();
        chk("full_s0", {28'd0, s}, 32'hF);
        for (int k = 1; k <= 4; k++) begin
            cmd_valid = 1'b1;
            cmd_s     = 4'(k);
            cmd_c     = 1'(k % 2);
            cmd_hold  = 8'(k - 1);
            chk("full_ready_k", {31'd0, cmd_ready}, 32'd1);
            tick();
        end
        cmd_s    = 4'h5;
        cmd_c    = 1'b1;
        cmd_hold = 8'd4;
        chk("full_ready0", {31'd0, cmd_ready}, 32'd0);
        chk("full_level4", {29'd0, fifo_level}, 32'd4);
        tick();
        chk("full_no_ovw", {29'd0, fifo_level}, 32'd4);
        chk("full_s0_run", {28'd0, s}, 32'hF);
        i = 0;
        while (!cmd_ready && i < 100) begin
            tick();
            i++;
        end
        chk("full_unstall", {31'd0, cmd_ready}, 32'd1);
        tick();  // fifth command pushed
        cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_sel("ord_start", 20);
            chk("ord_s", {28'd0, s}, 32'(k));
            chk("ord_c", {31'd0, c}, 32'(k % 2));
            wait_done("ord_done", 40);
            chk("ord_dto", {31'd0, done_timeout}, 32'd0);
            tick();
        end
        chk("ord_level0", {29'd0, fifo_level}, 32'd0);
        chk("ord_idle",   {31'd0, busy}, 32'd0);
        o = 1'b0;
        tick();
        tick();

        // ---------------- reset mid-command with two entries queued
        push(ring_cmd_t'{s: 4'h7, c: 1'b1, hold: 8'd10});
        tick();
        chk("mid_s", {28'd0, s}, 32'h7);
        push(ring_cmd_t'{s: 4'h2, c: 1'b0, hold: 8'd1});
        push(ring_cmd_t'{s: 4'h4, c: 1'b1, hold: 8'd1});
        chk("mid_level2",  {29'd0, fifo_level}, 32'd2);
        chk("mid_s_apply", {28'd0, s}, 32'h7);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_s",     {28'd0, s}, 32'd0);
        chk("mid_rst_c",     {31'd0, c}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_valid === 1'b1) seen_done = 1;
            if (busy === 1'b1) seen_busy = 1;
        end
        chk("mid_no_done",  seen_done, 32'd0);
        chk("mid_no_busy",  seen_busy, 32'd0);
        chk("mid_level_end", {29'd0, fifo_level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ring_stimulus_sequencer
`default_nettype wire
